// File: rtl/iq_sample_packer.sv
// IQ sample packer: reduces each I/Q component to OUT_BITS bits and packs N = WIDTH/(2*OUT_BITS)
// samples per output word, closing a word early on i_tlast so packets never share a word.
module iq_sample_packer #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned OUT_BITS = 4,
    parameter int unsigned ROUND    = 0,
    localparam int unsigned SlotW   = (OUT_BITS < 1) ? 2 : 2 * OUT_BITS,
    localparam int unsigned N       = WIDTH / SlotW,
    localparam int unsigned NvW     = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [NvW-1:0]   o_nvalid
);

    localparam int unsigned HW   = WIDTH / 2;
    localparam int unsigned Drop = HW - OUT_BITS;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CntW-1:0]     LastSlot = CntW'(N - 1);
    localparam logic [OUT_BITS-1:0] MaxPos   = {OUT_BITS{1'b1}} >> 1;
    localparam logic [HW:0]         Half     = (Drop > 0) ? ((HW + 1)'(1) << (Drop - 1)) : '0;

    if ((WIDTH % 2) != 0 || OUT_BITS < 1 || OUT_BITS > HW || (WIDTH % SlotW) != 0 || N < 2)
    begin : g_param_check
        $error("iq_sample_packer: illegal WIDTH/OUT_BITS combination");
    end

    logic [HW-1:0]       i_comp;
    logic [HW-1:0]       q_comp;
    logic [OUT_BITS-1:0] i_red;
    logic [OUT_BITS-1:0] q_red;

    assign i_comp = i_tdata[WIDTH-1 -: HW];
    assign q_comp = i_tdata[HW-1:0];

    if (ROUND != 0 && Drop > 0) begin : g_round
        logic [HW:0] i_sum;
        logic [HW:0] q_sum;
        logic        unused_sum;

        assign i_sum = {i_comp[HW-1], i_comp} + Half;
        assign q_sum = {q_comp[HW-1], q_comp} + Half;

        // Sign bits disagree only when a positive value carried past max positive.
        assign i_red = (i_sum[HW] != i_sum[HW-1]) ? MaxPos : i_sum[HW-1 -: OUT_BITS];
        assign q_red = (q_sum[HW] != q_sum[HW-1]) ? MaxPos : q_sum[HW-1 -: OUT_BITS];

        assign unused_sum = ^{i_sum[Drop-1:0], q_sum[Drop-1:0]};
    end else begin : g_trunc
        assign i_red = i_comp[HW-1 -: OUT_BITS];
        assign q_red = q_comp[HW-1 -: OUT_BITS];

        if (Drop > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^{i_comp[Drop-1:0], q_comp[Drop-1:0]};
        end
    end

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] tdata_q, tdata_d;
    logic             tlast_q, tlast_d;
    logic             tvalid_q, tvalid_d;
    logic [NvW-1:0]   nvalid_q, nvalid_d;

    logic             accept;
    logic             complete;
    logic [WIDTH-1:0] slot_word;
    logic [WIDTH-1:0] word;

    assign i_tready = ~tvalid_q | o_tready;
    assign accept   = i_tvalid & i_tready;
    assign complete = accept & ((cnt_q == LastSlot) | i_tlast);

    // Slot 0 sits at the top of the word; later slots move down by one slot width each.
    assign slot_word = {i_red, q_red, {(WIDTH - SlotW){1'b0}}} >> (int'(cnt_q) * SlotW);
    assign word      = acc_q | slot_word;

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        nvalid_d = nvalid_q;

        if (tvalid_q && o_tready) begin
            tvalid_d = 1'b0;
        end

        if (accept) begin
            if (complete) begin
                acc_d    = '0;
                cnt_d    = '0;
                tdata_d  = word;
                tlast_d  = i_tlast;
                tvalid_d = 1'b1;
                nvalid_d = NvW'(cnt_q) + NvW'(1);
            end else begin
                acc_d = word;
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            nvalid_q <= '0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            nvalid_q <= nvalid_d;
        end
    end

    assign o_tdata  = tdata_q;
    assign o_tlast  = tlast_q;
    assign o_tvalid = tvalid_q;
    assign o_nvalid = nvalid_q;

endmodule

// File: tb/tb_iq_sample_packer.sv
// Bench for iq_sample_packer: truncating and rounding instances share one input stream and are
// checked against directed vectors and a sample-queue reference model.
module tb_iq_sample_packer;

    localparam int W  = 32;
    localparam int B  = 4;
    localparam int N  = 4;
    localparam int HW = W / 2;

    typedef struct {
        logic [3:0][31:0] s;
        int               n;
        logic             last;
        logic [31:0]      exp0;
        logic [31:0]      exp1;
        logic [2:0]       nv;
    } vec_t;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        last;
        logic [2:0]  nv;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        o_tready = 1'b0;

    logic        i_tready0, o_tlast0, o_tvalid0;
    logic [31:0] o_tdata0;
    logic [2:0]  o_nvalid0;
    logic        i_tready1, o_tlast1, o_tvalid1;
    logic [31:0] o_tdata1;
    logic [2:0]  o_nvalid1;

    int checks = 0;
    int failures = 0;

    logic [32:0] pend[$];
    exp_t        expq[$];
    bit          stall_prev = 0;
    exp_t        held;

    iq_sample_packer #(.WIDTH(W), .OUT_BITS(B), .ROUND(0)) dut0 (
        .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(i_tready0), .o_tdata(o_tdata0), .o_tlast(o_tlast0), .o_tvalid(o_tvalid0),
        .o_tready(o_tready), .o_nvalid(o_nvalid0)
    );

    iq_sample_packer #(.WIDTH(W), .OUT_BITS(B), .ROUND(1)) dut1 (
        .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(i_tready1), .o_tdata(o_tdata1), .o_tlast(o_tlast1), .o_tvalid(o_tvalid1),
        .o_tready(o_tready), .o_nvalid(o_nvalid1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=bound expired required=event within bound", name);
    endtask

    // Reference reduction: plain integer floor division with clamp at max positive.
    function automatic logic [B-1:0] red(input logic [HW-1:0] c, input bit rnd);
        int v;
        int r;
        v = int'(signed'(c));
        if (rnd) r = (v + (1 << (HW - B - 1))) >>> (HW - B);
        else     r = v >>> (HW - B);
        if (r > (1 << (B - 1)) - 1) r = (1 << (B - 1)) - 1;
        return r[B-1:0];
    endfunction

    function automatic logic [31:0] pack(input bit rnd);
        logic [31:0] w;
        logic [31:0] slot;
        w = '0;
        for (int k = 0; k < pend.size(); k++) begin
            slot = {24'd0, red(pend[k][31:16], rnd), red(pend[k][15:0], rnd)};
            w    = w | (slot << (W - 2 * B * (k + 1)));
        end
        return w;
    endfunction

    task automatic monitor();
        exp_t e;
        if (reset) begin
            pend.delete();
            expq.delete();
            stall_prev = 0;
            return;
        end
        check("i_tready", {i_tready0, i_tready1}, {2{!o_tvalid0 || o_tready}});
        if (stall_prev) begin
            check("hold", {o_tvalid0, o_tdata0, o_tlast0, o_nvalid0, o_tdata1},
                  {1'b1, held.d0, held.last, held.nv, held.d1});
        end
        if (o_tvalid0 && o_tready) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_extra actual=word 0x%0h required=no word", o_tdata0);
            end else begin
                e = expq.pop_front();
                check("sb_data0", o_tdata0, e.d0);
                check("sb_data1", {o_tvalid1, o_tdata1}, {1'b1, e.d1});
                check("sb_tlast", {o_tlast0, o_tlast1}, {2{e.last}});
                check("sb_nvalid", {o_nvalid0, o_nvalid1}, {2{e.nv}});
            end
        end
        stall_prev = o_tvalid0 && !o_tready;
        held = '{d0: o_tdata0, d1: o_tdata1, last: o_tlast0, nv: o_nvalid0};
        if (i_tvalid && i_tready0) begin
            pend.push_back({i_tlast, i_tdata});
            if (pend.size() == N || i_tlast) begin
                e = '{d0: pack(0), d1: pack(1), last: i_tlast, nv: 3'(pend.size())};
                expq.push_back(e);
                pend.delete();
            end
        end
    endtask

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = !reset && i_tvalid && i_tready0;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bit a;
        a = 0;
        i_tdata  = d;
        i_tlast  = l;
        i_tvalid = 1'b1;
        for (int c = 0; c < 100 && !a; c++) tick(a);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        if (!a) fail_bound("send");
    endtask

    task automatic drain();
        bit a;
        int c;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        c = 0;
        while ((o_tvalid0 || expq.size() != 0) && c < 50) begin
            tick(a);
            c++;
        end
        if (o_tvalid0 || expq.size() != 0) fail_bound("drain");
    endtask

    function automatic vec_t mk(input logic [31:0] s0, s1, s2, s3, input int n, input logic last,
                                input logic [31:0] e0, e1, input logic [2:0] nv);
        vec_t v;
        v.s    = {s3, s2, s1, s0};
        v.n    = n;
        v.last = last;
        v.exp0 = e0;
        v.exp1 = e1;
        v.nv   = nv;
        return v;
    endfunction

    function automatic logic [15:0] rand_comp();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h7800 + 16'($urandom_range(0, 2047));
            3:       return 16'($urandom_range(0, 4095)) - 16'd2048;
            default: return 16'($urandom);
        endcase
    endfunction

    vec_t vecs[4];

    initial begin
        bit acc;
        int nacc;
        int cyc;

        // 0xFFFF is -1, which rounds half-up to 0 rather than keeping 0xF.
        vecs[0] = mk(32'h12345678, 32'h9ABCDEF0, 32'h00007FFF, 32'hFFFF8000, 4, 1'b1,
                     32'h159D07F8, 32'h15AE0708, 3'd4);
        vecs[1] = mk(32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 2, 1'b1,
                     32'h159D0000, 32'h15AE0000, 3'd2);
        vecs[2] = mk(32'h7FFF8000, 32'h0, 32'h0, 32'h0, 1, 1'b1,
                     32'h78000000, 32'h78000000, 3'd1);
        vecs[3] = mk(32'h80000000, 32'h7FF07FF0, 32'h07FF0800, 32'hF800F7FF, 4, 1'b0,
                     32'h807700FF, 32'h8077010F, 3'd4);

        #1 reset = 1'b1;
        #2;
        check("rst_out0", {o_tvalid0, o_tlast0, o_tdata0, o_nvalid0}, '0);
        check("rst_out1", {o_tvalid1, o_tlast1, o_tdata1, o_nvalid1}, '0);
        check("rst_ready", {i_tready0, i_tready1}, 2'b11);
        tick(acc);
        tick(acc);
        reset    = 1'b0;
        o_tready = 1'b1;

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                send(vecs[i].s[j], vecs[i].last && (j == vecs[i].n - 1));
            end
            check($sformatf("vec%0d_valid", i), o_tvalid0, 1'b1);
            check($sformatf("vec%0d_data0", i), o_tdata0, vecs[i].exp0);
            check($sformatf("vec%0d_data1", i), o_tdata1, vecs[i].exp1);
            check($sformatf("vec%0d_tlast", i), o_tlast0, vecs[i].last);
            check($sformatf("vec%0d_nvalid", i), o_nvalid0, vecs[i].nv);
        end
        drain();

        // Backpressure: word pending, further samples must wait without loss.
        o_tready = 1'b0;
        for (int j = 0; j < 4; j++) send(vecs[3].s[j], 1'b0);
        i_tvalid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            i_tdata = vecs[0].s[j];
            tick(acc);
            check("bp_accept", acc, 1'b0);
            check("bp_data", {o_tvalid0, o_tdata0}, {1'b1, vecs[3].exp0});
        end
        o_tready = 1'b1;
        for (int j = 0; j < 4; j++) send(vecs[0].s[j], j == 3);
        check("bp_next_data", o_tdata0, vecs[0].exp0);
        drain();

        // Asynchronous reset with a partial word accumulated.
        for (int j = 0; j < 3; j++) send(vecs[3].s[j], 1'b0);
        o_tready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_out0", {o_tvalid0, o_tlast0, o_tdata0, o_nvalid0}, '0);
        check("arst_out1", {o_tvalid1, o_tlast1, o_tdata1, o_nvalid1}, '0);
        check("arst_ready", {i_tready0, i_tready1}, 2'b11);
        tick(acc);
        tick(acc);
        reset = 1'b0;
        check("post_rst_ready", i_tready0, 1'b1);
        o_tready = 1'b1;
        send(32'h11112222, 1'b0);
        send(32'h33334444, 1'b0);
        send(32'h55556666, 1'b0);
        send(32'h77778888, 1'b0);
        check("arst_word0", {o_tvalid0, o_tdata0, o_nvalid0}, {1'b1, 32'h12345678, 3'd4});
        check("arst_word1", o_tdata1, 32'h12345679);
        drain();

        nacc = 0;
        cyc  = 0;
        acc  = 0;
        i_tvalid = 1'b0;
        while (nacc < 10000 && cyc < 80000) begin
            if (!i_tvalid || acc) begin
                i_tvalid = ($urandom_range(0, 3) != 0);
                i_tdata  = {rand_comp(), rand_comp()};
                i_tlast  = ($urandom_range(0, 5) == 0);
            end
            o_tready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) nacc++;
            cyc++;
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        if (nacc < 10000) fail_bound("random_stream");
        drain();
        check("sb_empty", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
